// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift sequencing controller, its shift register
// bench and future shift-direction variants.
package shift_pkg;

  localparam int WIDTH_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } shift_state_e;

  // Counter must hold every value 0..width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_amt_counter.sv
// Loadable down-counter holding the remaining shift positions, with zero/one
// flags used by the sequencer to decide when shifting is finished.
module shift_amt_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o,
  output logic             one_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == {CNT_W{1'b0}});
  assign one_o   = (count_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving a load/shift-left register: loads the operand, shifts it
// min(AMT, WIDTH) times, captures the register output and pulses DONE.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] OPERAND,
  input  logic [AMT_W-1:0] AMT,
  input  logic [WIDTH-1:0] SR_Q,
  output logic [WIDTH-1:0] SR_DIN,
  output logic             SHIFT_LOAD,
  output logic             SR_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int CNT_W = count_width(WIDTH);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_LOAD    = ST_LOAD;
  localparam logic [2:0] S_SHIFT   = ST_SHIFT;
  localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [2:0] S_DONE    = ST_DONE;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [WIDTH-1:0] sr_din_q;
  logic [WIDTH-1:0] result_q;
  logic             sr_en_q;
  logic             shift_load_q;
  logic             busy_q;
  logic             done_q;

  logic             accept_s;
  logic [CNT_W-1:0] amt_clamped_s;
  logic [CNT_W-1:0] count_s;
  logic             cnt_zero_s;
  logic             cnt_one_s;

  assign accept_s = (state_q == S_IDLE) && START;

  // Amounts at or beyond WIDTH all yield an all-zero register, so cap them.
  always_comb begin
    amt_clamped_s = {CNT_W{1'b0}};
    if (32'(AMT) >= $unsigned(WIDTH)) begin
      amt_clamped_s = CNT_W'(WIDTH);
    end else begin
      amt_clamped_s = CNT_W'(AMT);
    end
  end

  shift_amt_counter #(
    .CNT_W (CNT_W)
  ) u_amt_counter (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (accept_s),
    .load_val_i (amt_clamped_s),
    .dec_i      (state_q == S_SHIFT),
    .count_o    (count_s),
    .zero_o     (cnt_zero_s),
    .one_o      (cnt_one_s)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (START) state_d = S_LOAD;
        else       state_d = S_IDLE;
      end
      S_LOAD: begin
        if (cnt_zero_s) state_d = S_CAPTURE;
        else            state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_one_s || cnt_zero_s) state_d = S_CAPTURE;
        else                         state_d = S_SHIFT;
      end
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State, latched operand and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      sr_din_q <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      sr_din_q <= accept_s ? OPERAND : sr_din_q;
      result_q <= (state_q == S_CAPTURE) ? SR_Q : result_q;
    end
  end

  // Outputs decoded from the next state so they are registered yet Moore-aligned.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr_en_q      <= 1'b0;
      shift_load_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sr_en_q      <= (state_d == S_LOAD) || (state_d == S_SHIFT);
      shift_load_q <= (state_d == S_SHIFT) || (state_d == S_CAPTURE);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign SR_DIN     = sr_din_q;
  assign SHIFT_LOAD = shift_load_q;
  assign SR_EN      = sr_en_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign RESULT     = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 6-bit load/shift-left
// register closing the loop on SR_Q.
module tb_shift_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [5:0] OPERAND = 6'd0;
  logic [2:0] AMT = 3'd0;
  logic [5:0] sr_q;
  logic [5:0] SR_DIN;
  logic       SHIFT_LOAD;
  logic       SR_EN;
  logic       BUSY;
  logic       DONE;
  logic [5:0] RESULT;

  int checks = 0;
  int errors = 0;

  shift_seq_ctrl #(.WIDTH(6), .AMT_W(3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .OPERAND    (OPERAND),
    .AMT        (AMT),
    .SR_Q       (sr_q),
    .SR_DIN     (SR_DIN),
    .SHIFT_LOAD (SHIFT_LOAD),
    .SR_EN      (SR_EN),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .RESULT     (RESULT)
  );

  always #5 CLK = ~CLK;

  // Downstream shift register, reset by the same RST.
  always_ff @(posedge CLK) begin
    if (RST)        sr_q <= 6'd0;
    else if (SR_EN) sr_q <= SHIFT_LOAD ? {sr_q[4:0], 1'b0} : SR_DIN;
    else            sr_q <= sr_q;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One request; inj1/inj2 are cycle offsets at which a stray START is pulsed.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [2:0] amt,
                        input logic [5:0] exp_res, input int exp_n,
                        input int inj1, input int inj2);
    int shifts = 0;
    int busy_low = 0;
    int lat = 0;
    @(negedge CLK);
    START = 1'b1; OPERAND = op; AMT = amt;
    @(posedge CLK); #1;
    START = 1'b0; OPERAND = ~op; AMT = 3'd7;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (SR_EN && SHIFT_LOAD) shifts++;
      if (!BUSY) busy_low++;
      START = (k == inj1) || (k == inj2);
      if (START) begin OPERAND = 6'b111111; AMT = 3'd1; end
      if (DONE) begin lat = k; break; end
    end
    check({tag, "_latency"}, lat, exp_n + 3);
    check({tag, "_shift_cycles"}, shifts, exp_n);
    check({tag, "_busy_gaps"}, busy_low, 0);
    check({tag, "_result"}, RESULT, exp_res);
    check({tag, "_sr_din"}, SR_DIN, op);
    @(negedge CLK);
    START = 1'b0;
    check({tag, "_done_one_cycle"}, DONE, 0);
    check({tag, "_idle_busy"}, BUSY, 0);
  endtask

  initial begin
    int dones;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_outputs", {SR_DIN, RESULT, SR_EN, SHIFT_LOAD, BUSY, DONE}, 0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("idle_sr_en", SR_EN, 0);
      check("idle_busy", BUSY, 0);
    end

    run_op("basic", 6'b000101, 3'd2, 6'b010100, 2, 0, 0);
    run_op("zero_amt", 6'b101101, 3'd0, 6'b101101, 0, 0, 0);
    run_op("clamp", 6'b111111, 3'd7, 6'b000000, 6, 0, 0);
    run_op("amt6", 6'b000001, 3'd6, 6'b000000, 6, 0, 0);
    run_op("amt5", 6'b000001, 3'd5, 6'b100000, 5, 0, 0);

    // Stray STARTs during SHIFT (cycle 3) and during DONE (cycle 6).
    run_op("busy_start", 6'b000011, 3'd3, 6'b011000, 3, 3, 6);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) dones++;
    end
    check("busy_start_no_second_op", dones, 0);
    check("busy_start_result_held", RESULT, 6'b011000);

    // Reset during the second SHIFT cycle of a 5-shift request.
    @(negedge CLK);
    START = 1'b1; OPERAND = 6'b000111; AMT = 3'd5;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check("abort_in_shift", {SR_EN, SHIFT_LOAD, BUSY}, 3'b111);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_outputs", {SR_DIN, RESULT, SR_EN, SHIFT_LOAD, BUSY, DONE}, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op("after_abort", 6'b100001, 3'd1, 6'b000010, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
